// File: rtl/mc_control_fsm_pkg.sv
// Shared constants for the multicycle MIPS control unit:
// state encodings, opcodes, functs, ALU codes, ALUSrcB selects.
package mc_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t FETCH    = 4'd0;
  localparam state_t DECODE   = 4'd1;
  localparam state_t MEMADR   = 4'd2;
  localparam state_t MEMRD    = 4'd3;
  localparam state_t MEMWB    = 4'd4;
  localparam state_t MEMWR    = 4'd5;
  localparam state_t RTYPE_EX = 4'd6;
  localparam state_t RTYPE_WB = 4'd7;
  localparam state_t ADDI_EX  = 4'd8;
  localparam state_t ADDI_WB  = 4'd9;
  localparam state_t BRANCH   = 4'd10;
  localparam state_t JUMP     = 4'd11;
  localparam state_t GPIN_EX  = 4'd12;
  localparam state_t ILLEGAL  = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_JMP = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// R-type funct decoder: funct -> ALU operation plus a valid flag.
// Ports: funct (in 6), alu_ctrl (out 3), funct_valid (out 1).
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_NOR:  alu_ctrl = ALU_NOR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: state register, next-state and Moore output decode.
// Ports: clk, reset, op, Funct, zero in; datapath selects/enables, illegal_o, instr_done_o, state_o out.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] GPIN_OP = 6'h3E,
  parameter int         STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         Funct,
  input  logic               zero,
  output logic               PCen,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               PCsrc,
  output logic               Ori,
  output logic [2:0]         ALUControl,
  output logic               illegal_o,
  output logic               instr_done_o,
  output logic [STATE_W-1:0] state_o
);

  state_t     state;
  state_t     state_nx;
  state_t     cur;
  logic [2:0] fn_alu;
  logic       fn_ok;

  alu_decoder u_dec (
    .funct       (Funct),
    .alu_ctrl    (fn_alu),
    .funct_valid (fn_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:  state_nx = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW)        state_nx = MEMADR;
        else if (op == OP_RTYPE)               state_nx = RTYPE_EX;
        else if (op == OP_ADDI)                state_nx = ADDI_EX;
        else if (op == OP_BEQ || op == OP_BNE) state_nx = BRANCH;
        else if (op == OP_J)                   state_nx = JUMP;
        else if (op == GPIN_OP)                state_nx = GPIN_EX;
        else                                   state_nx = ILLEGAL;
      end
      MEMADR:   state_nx = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_nx = MEMWB;
      RTYPE_EX: state_nx = fn_ok ? RTYPE_WB : ILLEGAL;
      ADDI_EX:  state_nx = ADDI_WB;
      GPIN_EX:  state_nx = ADDI_WB;
      default:  state_nx = FETCH;
    endcase
  end

  // Under reset the selects show FETCH values; enables are masked below.
  assign cur = reset ? FETCH : state;

  always_comb begin
    PCen         = 1'b0;
    IorD         = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REG;
    PCsrc        = 1'b0;
    Ori          = 1'b0;
    ALUControl   = ALU_ADD;
    illegal_o    = 1'b0;
    instr_done_o = 1'b0;
    case (cur)
      FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCen    = 1'b1;
      end
      DECODE: ALUSrcB = SRCB_IMMSH;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg     = 1'b1;
        RegWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      MEMWR: begin
        IorD         = 1'b1;
        MemWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      RTYPE_EX: begin
        ALUSrcA    = 1'b1;
        ALUControl = fn_alu;
      end
      RTYPE_WB: begin
        RegDst       = 1'b1;
        RegWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ADDI_WB: begin
        RegWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUControl   = ALU_SUB;
        PCsrc        = 1'b1;
        PCen         = (op == OP_BNE) ? ~zero : zero;
        instr_done_o = 1'b1;
      end
      JUMP: begin
        ALUControl   = ALU_JMP;
        PCen         = 1'b1;
        instr_done_o = 1'b1;
      end
      GPIN_EX: begin
        Ori     = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ILLEGAL: begin
        illegal_o    = 1'b1;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCen    = 1'b0;
      IRWrite = 1'b0;
    end
  end

  assign state_o = state;

endmodule
